vend_sequencer: RTL and testbench
=================================

// Module: vend_sequencer
// PURPOSE
//  Transaction sequencer for the vending datapath: turns button/coin events into price,
//  balance, change and sales-total registers, and drives a coin-hopper payout handshake.
//  Sits between the button inputs and the hex->BCD/7-seg display path.
//  All state runs on a single clock; slow timing uses a 1-cycle tick enable.
// PARAMETERS
//  BAL_W          4   width of price/coinBalance/change/total
//  MAX_BAL        15  largest balance accepted; a coin that would exceed it is rejected
//  ALARM_TICKS    3   ticks alarm stays high after an error; retriggerable
//  TIMEOUT_TICKS  30  idle ticks before auto-refund (VEND_TIMEOUT_EN only)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous, active-low reset
//  tick         in   1      1-cycle pulse, nominally 1 Hz (alarm/timeout timebase)
//  coin1/2/5/10 in   1 each level inputs; rising edge = one coin inserted
//  select1/2/5/10 in 1 each level inputs; rising edge = choose item of that price
//  confirm      in   1      rising edge = buy selected item
//  cancel       in   1      rising edge = refund balance
//  resetTotal   in   1      rising edge = clear sales total
//  pay_ack      in   1      hopper accepted current coin
//  pay_req      out  1      hopper request; held until pay_ack
//  pay_val      out  BAL_W  denomination to pay out (10/5/2/1); stable while pay_req=1
//  price        out  BAL_W  price of selected item, 0 = none
//  coinBalance  out  BAL_W  money inserted in current transaction
//  change       out  BAL_W  change/refund of the last transaction
//  total        out  BAL_W  saturating sales total
//  selectItem   out  4      one-hot item sold {10,5,2,1}
//  alarm        out  1      error indication
//  busy         out  1      high in VEND and PAYOUT
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, edge-detect history 0; mid-payout reset drops pay_req, owed change is lost.
//  - All level inputs are rising-edge detected; one registered history bit per input; an event occurs the cycle after the rise.
//  - FSM IDLE/COLLECT/VEND/PAYOUT; IDLE <=> balance==0 outside VEND/PAYOUT.
//  - Coin edge (IDLE/COLLECT): balance+=value -> COLLECT; clear selectItem/change. If sum>MAX_BAL: reject, balance kept, alarm.
//  - >1 coin edge same cycle: all rejected, alarm. >1 select edge same cycle: ignored, alarm.
//  - Select edge (IDLE/COLLECT): price<=item price; clear selectItem.
//  - confirm edge -> VEND next cycle; a coin accepted in the confirm cycle counts.
//  - VEND (1 cycle): price==0 or balance<price -> alarm, back to COLLECT/IDLE, nothing changes.
//    Else change=balance-price, selectItem set, total=min(total+price, 2^BAL_W-1), balance=0, price=0;
//    -> PAYOUT if change!=0 else IDLE.
//  - cancel edge in COLLECT: change=balance, balance=0, -> PAYOUT; selectItem stays 0.
//  - PAYOUT: remaining=change; pay_val=largest of {10,5,2,1} <= remaining; on pay_req&pay_ack
//    remaining-=pay_val, pay_req drops for 1 cycle; remaining==0 -> IDLE. change output stays stable.
//  - In VEND/PAYOUT: coin edges rejected with alarm; select/confirm/cancel ignored.
//  - resetTotal: total<=0 in any state; coincident with VEND commit -> total<=price.
//  - alarm: on error, counter=ALARM_TICKS, decremented per tick; alarm=(counter!=0).
// CONFIGURATION
//  VEND_TIMEOUT_EN defined: in COLLECT, idle counter reloads on any input edge, counts ticks;
//   reaching TIMEOUT_TICKS acts exactly as cancel. Undefined: no counter; COLLECT holds forever.
// STRUCTURE
//  vend_pkg: state enum, coin/item value constants, greedy next_denom() function.
//  Sub-module vend_edge_det: N-bit rising-edge detector, async active-low reset.
// TESTING
//  coin5,coin5,select10,confirm -> balance 10, VEND: selectItem=4'b1000, change=0, total=10, IDLE
//  coin10,coin5,select2,confirm -> change=13; pay_val 10,2,1 across three acks; then IDLE
//  balance 10 + coin10 -> rejected, balance 10, alarm high 3 ticks; coin1+coin2 same cycle -> both rejected
//  select5, coin2, confirm -> alarm, balance 2 kept; cancel -> pay_val 2, change=2, IDLE
//  rst low during PAYOUT with pay_req=1 -> pay_req 0 immediately, all outputs 0
//  VEND_TIMEOUT_EN: coin1 then 30 ticks idle -> refund pay_val=1; undefined: balance held

Source files
------------

// File: rtl/vend_pkg.sv
// Shared constants and helpers for the vending sequencer: FSM encodings,
// coin/item values and the greedy payout denomination picker.
package vend_pkg;

    localparam int VEND_BAL_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_VEND    = 2'd2;
    localparam logic [1:0] ST_PAYOUT  = 2'd3;

    localparam logic [VEND_BAL_W-1:0] VAL_1  = VEND_BAL_W'(1);
    localparam logic [VEND_BAL_W-1:0] VAL_2  = VEND_BAL_W'(2);
    localparam logic [VEND_BAL_W-1:0] VAL_5  = VEND_BAL_W'(5);
    localparam logic [VEND_BAL_W-1:0] VAL_10 = VEND_BAL_W'(10);

    // Largest hopper denomination not exceeding the amount still owed.
    function automatic logic [VEND_BAL_W-1:0] next_denom(input logic [VEND_BAL_W-1:0] rem);
        if (rem >= VAL_10)     return VAL_10;
        else if (rem >= VAL_5) return VAL_5;
        else if (rem >= VAL_2) return VAL_2;
        else if (rem != '0)    return VAL_1;
        else                   return '0;
    endfunction

    // One-hot {10,5,2,1} to value; non-one-hot codes map to zero.
    function automatic logic [VEND_BAL_W-1:0] onehot_value(input logic [3:0] oh);
        case (oh)
            4'b0001: return VAL_1;
            4'b0010: return VAL_2;
            4'b0100: return VAL_5;
            4'b1000: return VAL_10;
            default: return '0;
        endcase
    endfunction

    function automatic logic [3:0] value_onehot(input logic [VEND_BAL_W-1:0] v);
        case (v)
            VAL_1:   return 4'b0001;
            VAL_2:   return 4'b0010;
            VAL_5:   return 4'b0100;
            VAL_10:  return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/vend_edge_det.sv
// N-bit rising-edge detector; each rise yields a registered one-cycle pulse
// in the cycle after the input is first sampled high.
module vend_edge_det #(
    parameter int N = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] rise_o
);

    logic [N-1:0] hist_q;
    logic [N-1:0] rise_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist_q <= '0;
            rise_q <= '0;
        end else begin
            hist_q <= d_i;
            rise_q <= d_i & ~hist_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: coin/button events to price, balance, change and
// sales total, plus hopper payout handshake. Optional auto-refund: VEND_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   IDLE     | no money inserted, waiting for coin/select
//   COLLECT  | balance nonzero, accepting coins/select/confirm/cancel
//   VEND     | one-cycle purchase evaluation and commit
//   PAYOUT   | paying change/refund through the hopper
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int BAL_W         = VEND_BAL_W,
    parameter int MAX_BAL       = 15,
    parameter int ALARM_TICKS   = 3,
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             tick_i,
    input  logic             coin1_i,
    input  logic             coin2_i,
    input  logic             coin5_i,
    input  logic             coin10_i,
    input  logic             select1_i,
    input  logic             select2_i,
    input  logic             select5_i,
    input  logic             select10_i,
    input  logic             confirm_i,
    input  logic             cancel_i,
    input  logic             resetTotal_i,
    input  logic             pay_ack_i,
    output logic             pay_req_o,
    output logic [BAL_W-1:0] pay_val_o,
    output logic [BAL_W-1:0] price_o,
    output logic [BAL_W-1:0] coinBalance_o,
    output logic [BAL_W-1:0] change_o,
    output logic [BAL_W-1:0] total_o,
    output logic [3:0]       selectItem_o,
    output logic             alarm_o,
    output logic             busy_o
);

    localparam int AW = $clog2(ALARM_TICKS + 1);
    localparam logic [BAL_W:0] MAX_BAL_L = (BAL_W + 1)'(MAX_BAL);

    logic [10:0] in_lvl;
    logic [10:0] rise;
    logic [3:0]  coin_e;
    logic [3:0]  sel_e;
    logic        confirm_e;
    logic        cancel_e;
    logic        rtot_e;
    logic        timeout_e;

    logic [1:0]       state_q, state_d;
    logic [BAL_W-1:0] bal_q, bal_d;
    logic [BAL_W-1:0] price_q, price_d;
    logic [BAL_W-1:0] change_q, change_d;
    logic [BAL_W-1:0] total_q, total_d;
    logic [BAL_W-1:0] rem_q, rem_d;
    logic [3:0]       item_q, item_d;
    logic             pay_req_q, pay_req_d;
    logic [AW-1:0]    alarm_q, alarm_d;

    logic [BAL_W-1:0] pay_val;
    logic [BAL_W-1:0] bal_n;
    logic [BAL_W-1:0] chg_n;
    logic [BAL_W:0]   coin_sum;
    logic [BAL_W:0]   total_sum;
    logic             err;
    logic             commit;

    assign in_lvl = {resetTotal_i, cancel_i, confirm_i,
                     select10_i, select5_i, select2_i, select1_i,
                     coin10_i, coin5_i, coin2_i, coin1_i};

    vend_edge_det #(.N(11)) u_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (in_lvl),
        .rise_o  (rise)
    );

    assign coin_e    = rise[3:0];
    assign sel_e     = rise[7:4];
    assign confirm_e = rise[8];
    assign cancel_e  = rise[9];
    assign rtot_e    = rise[10];

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] to_q, to_d;

    // Counter sits at full load outside COLLECT, so entry always starts a fresh window.
    always_comb begin
        to_d      = to_q;
        timeout_e = 1'b0;
        if (state_q != ST_COLLECT || rise != '0) begin
            to_d = TW'(TIMEOUT_TICKS);
        end else if (tick_i) begin
            if (to_q == TW'(1)) begin
                timeout_e = 1'b1;
                to_d      = TW'(TIMEOUT_TICKS);
            end else begin
                to_d = to_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) to_q <= TW'(TIMEOUT_TICKS);
        else          to_q <= to_d;
    end
`else
    assign timeout_e = 1'b0;
`endif

    assign pay_val   = (state_q == ST_PAYOUT) ? next_denom(rem_q) : '0;
    assign coin_sum  = {1'b0, bal_q} + {1'b0, onehot_value(coin_e)};
    assign total_sum = {1'b0, total_q} + {1'b0, price_q};

    always_comb begin
        state_d   = state_q;
        bal_d     = bal_q;
        price_d   = price_q;
        change_d  = change_q;
        total_d   = total_q;
        rem_d     = rem_q;
        item_d    = item_q;
        pay_req_d = pay_req_q;
        bal_n     = bal_q;
        chg_n     = '0;
        err       = 1'b0;
        commit    = 1'b0;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (coin_e != '0) begin
                    if ((coin_e & (coin_e - 4'd1)) != '0 || coin_sum > MAX_BAL_L) begin
                        err = 1'b1;
                    end else begin
                        bal_n    = coin_sum[BAL_W-1:0];
                        item_d   = '0;
                        change_d = '0;
                    end
                end
                if (sel_e != '0) begin
                    if ((sel_e & (sel_e - 4'd1)) != '0) begin
                        err = 1'b1;
                    end else begin
                        price_d = onehot_value(sel_e);
                        item_d  = '0;
                    end
                end
                bal_d   = bal_n;
                state_d = (bal_n != '0) ? ST_COLLECT : ST_IDLE;
                if (confirm_e) begin
                    state_d = ST_VEND;
                end else if ((cancel_e || timeout_e) && state_q == ST_COLLECT) begin
                    change_d  = bal_n;
                    bal_d     = '0;
                    rem_d     = bal_n;
                    pay_req_d = (bal_n != '0);
                    state_d   = (bal_n != '0) ? ST_PAYOUT : ST_IDLE;
                end
            end
            ST_VEND: begin
                if (coin_e != '0) err = 1'b1;
                if (price_q == '0 || bal_q < price_q) begin
                    err     = 1'b1;
                    state_d = (bal_q != '0) ? ST_COLLECT : ST_IDLE;
                end else begin
                    commit    = 1'b1;
                    chg_n     = bal_q - price_q;
                    change_d  = chg_n;
                    item_d    = value_onehot(price_q);
                    total_d   = total_sum[BAL_W] ? '1 : total_sum[BAL_W-1:0];
                    bal_d     = '0;
                    price_d   = '0;
                    rem_d     = chg_n;
                    pay_req_d = (chg_n != '0);
                    state_d   = (chg_n != '0) ? ST_PAYOUT : ST_IDLE;
                end
            end
            default: begin
                if (coin_e != '0) err = 1'b1;
                // Request drops for one cycle after each accepted coin.
                if (pay_req_q && pay_ack_i) begin
                    rem_d     = rem_q - pay_val;
                    pay_req_d = 1'b0;
                    if (rem_q == pay_val) state_d = ST_IDLE;
                end else if (!pay_req_q) begin
                    pay_req_d = 1'b1;
                end
            end
        endcase

        if (rtot_e) total_d = commit ? price_q : '0;

        alarm_d = alarm_q;
        if (err)                             alarm_d = AW'(ALARM_TICKS);
        else if (tick_i && alarm_q != '0)    alarm_d = alarm_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            bal_q     <= '0;
            price_q   <= '0;
            change_q  <= '0;
            total_q   <= '0;
            rem_q     <= '0;
            item_q    <= '0;
            pay_req_q <= 1'b0;
            alarm_q   <= '0;
        end else begin
            state_q   <= state_d;
            bal_q     <= bal_d;
            price_q   <= price_d;
            change_q  <= change_d;
            total_q   <= total_d;
            rem_q     <= rem_d;
            item_q    <= item_d;
            pay_req_q <= pay_req_d;
            alarm_q   <= alarm_d;
        end
    end

    assign pay_req_o     = pay_req_q;
    assign pay_val_o     = pay_val;
    assign price_o       = price_q;
    assign coinBalance_o = bal_q;
    assign change_o      = change_q;
    assign total_o       = total_q;
    assign selectItem_o  = item_q;
    assign alarm_o       = (alarm_q != '0);
    assign busy_o        = (state_q == ST_VEND) || (state_q == ST_PAYOUT);

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer; timeout section follows VEND_TIMEOUT_EN.
module tb_vend_sequencer;

    localparam logic [10:0] C1   = 11'h001;
    localparam logic [10:0] C2   = 11'h002;
    localparam logic [10:0] C5   = 11'h004;
    localparam logic [10:0] C10  = 11'h008;
    localparam logic [10:0] S2   = 11'h020;
    localparam logic [10:0] S5   = 11'h040;
    localparam logic [10:0] S10  = 11'h080;
    localparam logic [10:0] CONF = 11'h100;
    localparam logic [10:0] CANC = 11'h200;
    localparam logic [10:0] RTOT = 11'h400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        pay_ack = 1'b0;
    logic [10:0] lvl = '0;
    logic        pay_req;
    logic [3:0]  pay_val, price, bal, change, total, item;
    logic        alarm, busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vend_sequencer dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .tick_i        (tick),
        .coin1_i       (lvl[0]),
        .coin2_i       (lvl[1]),
        .coin5_i       (lvl[2]),
        .coin10_i      (lvl[3]),
        .select1_i     (lvl[4]),
        .select2_i     (lvl[5]),
        .select5_i     (lvl[6]),
        .select10_i    (lvl[7]),
        .confirm_i     (lvl[8]),
        .cancel_i      (lvl[9]),
        .resetTotal_i  (lvl[10]),
        .pay_ack_i     (pay_ack),
        .pay_req_o     (pay_req),
        .pay_val_o     (pay_val),
        .price_o       (price),
        .coinBalance_o (bal),
        .change_o      (change),
        .total_o       (total),
        .selectItem_o  (item),
        .alarm_o       (alarm),
        .busy_o        (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [10:0] m);
        lvl = m;
        cyc(1);
        lvl = '0;
        cyc(3);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    task automatic ack_coin(input int expv);
        int w;
        w = 0;
        while (!pay_req && w < 20) begin
            cyc(1);
            w++;
        end
        chk("pay_req_wait", int'(pay_req), 1);
        chk("pay_val", int'(pay_val), expv);
        pay_ack = 1'b1;
        cyc(1);
        pay_ack = 1'b0;
        chk("pay_req_drop", int'(pay_req), 0);
    endtask

    initial begin
        cyc(3);
        chk("rst_pay_req", int'(pay_req), 0);
        chk("rst_bal", int'(bal), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        cyc(2);

        // Exact purchase
        pulse(C5);
        pulse(C5);
        chk("t1_bal", int'(bal), 10);
        pulse(S10);
        chk("t1_price", int'(price), 10);
        pulse(CONF);
        chk("t1_item", int'(item), 8);
        chk("t1_change", int'(change), 0);
        chk("t1_total", int'(total), 10);
        chk("t1_bal0", int'(bal), 0);
        chk("t1_price0", int'(price), 0);
        chk("t1_busy", int'(busy), 0);

        // Purchase with 13 change
        pulse(C10);
        pulse(C5);
        chk("t2_bal", int'(bal), 15);
        pulse(S2);
        pulse(CONF);
        chk("t2_change", int'(change), 13);
        chk("t2_total", int'(total), 12);
        chk("t2_item", int'(item), 2);
        chk("t2_busy", int'(busy), 1);
        ack_coin(10);
        ack_coin(2);
        ack_coin(1);
        cyc(1);
        chk("t2_busy_end", int'(busy), 0);
        chk("t2_change_hold", int'(change), 13);

        // Overflow and multi-coin rejection, alarm timing
        pulse(C10);
        chk("t3_change_clr", int'(change), 0);
        pulse(C10);
        chk("t3_bal_kept", int'(bal), 10);
        chk("t3_alarm", int'(alarm), 1);
        do_tick();
        do_tick();
        chk("t3_alarm_2t", int'(alarm), 1);
        do_tick();
        chk("t3_alarm_3t", int'(alarm), 0);
        pulse(C1 | C2);
        chk("t3_multi_bal", int'(bal), 10);
        chk("t3_multi_alarm", int'(alarm), 1);
        pulse(CANC);
        chk("t3_refund", int'(change), 10);
        ack_coin(10);
        cyc(1);
        chk("t3_bal0", int'(bal), 0);
        do_tick();
        do_tick();
        do_tick();
        chk("t3_alarm_clr", int'(alarm), 0);

        // Insufficient balance then cancel
        pulse(S5);
        pulse(C2);
        pulse(CONF);
        chk("t4_alarm", int'(alarm), 1);
        chk("t4_bal", int'(bal), 2);
        chk("t4_price", int'(price), 5);
        chk("t4_busy", int'(busy), 0);
        chk("t4_total", int'(total), 12);
        pulse(CANC);
        chk("t4_change", int'(change), 2);
        chk("t4_item", int'(item), 0);
        ack_coin(2);
        cyc(1);
        chk("t4_idle", int'(busy), 0);
        chk("t4_bal0", int'(bal), 0);

        // Total saturation, resetTotal coincident with commit, plain resetTotal
        pulse(C10);
        pulse(S10);
        pulse(CONF);
        chk("t5_sat", int'(total), 15);
        pulse(C5);
        pulse(S5);
        lvl = CONF;
        cyc(1);
        lvl = RTOT;
        cyc(1);
        lvl = '0;
        cyc(3);
        chk("t5_rtot_commit", int'(total), 5);
        chk("t5_item", int'(item), 4);
        pulse(RTOT);
        chk("t5_rtot", int'(total), 0);

        // Reset during payout
        pulse(C10);
        pulse(C1);
        pulse(S10);
        pulse(CONF);
        chk("t6_pay_req", int'(pay_req), 1);
        chk("t6_pay_val", int'(pay_val), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pay_req", int'(pay_req), 0);
        chk("t6_rst_change", int'(change), 0);
        chk("t6_rst_total", int'(total), 0);
        chk("t6_rst_item", int'(item), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_pay_val", int'(pay_val), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // Idle timeout behaviour
        pulse(C1);
        repeat (29) do_tick();
        chk("t7_bal_29", int'(bal), 1);
        chk("t7_busy_29", int'(busy), 0);
`ifdef VEND_TIMEOUT_EN
        do_tick();
        chk("t7_timeout_busy", int'(busy), 1);
        chk("t7_timeout_change", int'(change), 1);
        ack_coin(1);
        cyc(1);
        chk("t7_bal0", int'(bal), 0);
`else
        repeat (6) do_tick();
        chk("t7_bal_held", int'(bal), 1);
        chk("t7_busy_held", int'(busy), 0);
        pulse(CANC);
        ack_coin(1);
        cyc(1);
        chk("t7_bal0", int'(bal), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
